// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and default keymap for the tank controller family
package tank_pkg;

    typedef enum logic [2:0] {
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        REQ      = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_t;

    localparam logic [7:0] KEY_UP_DEF    = 8'h52;
    localparam logic [7:0] KEY_DOWN_DEF  = 8'h51;
    localparam logic [7:0] KEY_LEFT_DEF  = 8'h50;
    localparam logic [7:0] KEY_RIGHT_DEF = 8'h4F;
    localparam logic [7:0] KEY_FIRE_DEF  = 8'h58;

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - frame strobe synchroniser and rising-edge pulse generator
module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);

    logic s1, s2, s3;

    // Two flops resolve metastability; the third holds the previous level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= frame_clk;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/tank_ctrl_gen.sv
// rtl/tank_ctrl_gen.sv - keyboard-driven player tank: clamped motion and rate-limited fire requests
module tank_ctrl_gen
    import tank_pkg::*;
#(
    parameter int NUM_KEYS      = 6,
    parameter int X_START       = 140,
    parameter int Y_START       = 240,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int Y_MIN         = 0,
    parameter int Y_MAX         = 479,
    parameter int STEP          = 1,
    parameter int WIDTH         = 32,
    parameter int HEIGHT        = 32,
    parameter int FIRE_COOLDOWN = 15,
    parameter logic [7:0] KEY_UP    = KEY_UP_DEF,
    parameter logic [7:0] KEY_DOWN  = KEY_DOWN_DEF,
    parameter logic [7:0] KEY_LEFT  = KEY_LEFT_DEF,
    parameter logic [7:0] KEY_RIGHT = KEY_RIGHT_DEF,
    parameter logic [7:0] KEY_FIRE  = KEY_FIRE_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_clk,
    input  logic [8*NUM_KEYS-1:0]   keycodes,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic                    is_tank,
    output logic [9:0]              tank_X,
    output logic [9:0]              tank_Y,
    output logic [2:0]              tank_dir,
    output logic                    fire_req,
    input  logic                    fire_ack,
    output logic [9:0]              shot_X,
    output logic [9:0]              shot_Y,
    output logic [2:0]              shot_dir,
    output logic                    cooldown_busy
);

    localparam int CNT_W = $clog2(FIRE_COOLDOWN + 2);

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] X_LO   = 11'(X_MIN);
    localparam logic [10:0] Y_LO   = 11'(Y_MIN);
    localparam logic [10:0] X_HI   = 11'(X_MAX + 1 - WIDTH);
    localparam logic [10:0] Y_HI   = 11'(Y_MAX + 1 - HEIGHT);
    localparam logic [10:0] W_EXT  = 11'(WIDTH);
    localparam logic [10:0] H_EXT  = 11'(HEIGHT);

    logic              frame_tick;
    logic              up_held, down_held, left_held, right_held, fire_held;
    logic [9:0]        tank_x_q, tank_y_q;
    dir_t              dir_q;
    logic [9:0]        x_next, y_next;
    dir_t              dir_next;
    logic [10:0]       x_ext, y_ext;
    logic [9:0]        muzzle_x, muzzle_y;
    fire_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              latch_shot, load_cnt, dec_cnt;
    logic [9:0]        shot_x_q, shot_y_q;
    logic [2:0]        shot_dir_q;

    frame_tick_sync u_sync (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (frame_tick)
    );

    always_comb begin
        up_held    = 1'b0;
        down_held  = 1'b0;
        left_held  = 1'b0;
        right_held = 1'b0;
        fire_held  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[8*i +: 8] == KEY_UP)    up_held    = 1'b1;
            if (keycodes[8*i +: 8] == KEY_DOWN)  down_held  = 1'b1;
            if (keycodes[8*i +: 8] == KEY_LEFT)  left_held  = 1'b1;
            if (keycodes[8*i +: 8] == KEY_RIGHT) right_held = 1'b1;
            if (keycodes[8*i +: 8] == KEY_FIRE)  fire_held  = 1'b1;
        end
    end

    assign x_ext = {1'b0, tank_x_q};
    assign y_ext = {1'b0, tank_y_q};

    // 11-bit sums keep the clamp comparisons free of wrap near either arena edge.
    always_comb begin
        x_next   = tank_x_q;
        y_next   = tank_y_q;
        dir_next = dir_q;
        if (up_held) begin
            dir_next = DIR_UP;
            y_next   = (y_ext < Y_LO + STEP_W) ? 10'(Y_LO) : 10'(y_ext - STEP_W);
        end else if (down_held) begin
            dir_next = DIR_DOWN;
            y_next   = (y_ext + STEP_W > Y_HI) ? 10'(Y_HI) : 10'(y_ext + STEP_W);
        end else if (left_held) begin
            dir_next = DIR_LEFT;
            x_next   = (x_ext < X_LO + STEP_W) ? 10'(X_LO) : 10'(x_ext - STEP_W);
        end else if (right_held) begin
            dir_next = DIR_RIGHT;
            x_next   = (x_ext + STEP_W > X_HI) ? 10'(X_HI) : 10'(x_ext + STEP_W);
        end
    end

    // Muzzle sits on the leading edge of the pre-move sprite, facing the new direction.
    always_comb begin
        muzzle_x = tank_x_q + 10'(WIDTH - 1);
        muzzle_y = tank_y_q + 10'(HEIGHT / 2);
        case (dir_next)
            DIR_UP: begin
                muzzle_x = tank_x_q + 10'(WIDTH / 2);
                muzzle_y = tank_y_q;
            end
            DIR_DOWN: begin
                muzzle_x = tank_x_q + 10'(WIDTH / 2);
                muzzle_y = tank_y_q + 10'(HEIGHT - 1);
            end
            DIR_LEFT: begin
                muzzle_x = tank_x_q;
                muzzle_y = tank_y_q + 10'(HEIGHT / 2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tank_x_q <= 10'(X_START);
            tank_y_q <= 10'(Y_START);
            dir_q    <= DIR_UP;
        end else if (frame_tick) begin
            tank_x_q <= x_next;
            tank_y_q <= y_next;
            dir_q    <= dir_next;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_shot = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        case (state_q)
            READY: begin
                if (frame_tick && fire_held) begin
                    latch_shot = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (fire_ack) begin
                    load_cnt = 1'b1;
                    state_d  = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cnt_q == '0) state_d = READY;
                else if (frame_tick) dec_cnt = 1'b1;
            end
            default: state_d = READY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= READY;
            cnt_q      <= '0;
            shot_x_q   <= '0;
            shot_y_q   <= '0;
            shot_dir_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_cnt) cnt_q <= CNT_W'(FIRE_COOLDOWN);
            else if (dec_cnt) cnt_q <= cnt_q - 1'b1;
            if (latch_shot) begin
                shot_x_q   <= muzzle_x;
                shot_y_q   <= muzzle_y;
                shot_dir_q <= dir_next;
            end
        end
    end

    assign tank_X        = tank_x_q;
    assign tank_Y        = tank_y_q;
    assign tank_dir      = dir_q;
    assign fire_req      = (state_q == REQ);
    assign cooldown_busy = (state_q != READY);
    assign shot_X        = shot_x_q;
    assign shot_Y        = shot_y_q;
    assign shot_dir      = shot_dir_q;

    assign is_tank = ({1'b0, DrawX} >= x_ext) && ({1'b0, DrawX} < x_ext + W_EXT) &&
                     ({1'b0, DrawY} >= y_ext) && ({1'b0, DrawY} < y_ext + H_EXT);

endmodule

// File: tb/tb_tank_ctrl_gen.sv
// tb/tb_tank_ctrl_gen.sv - scoreboard bench for tank_ctrl_gen against a frame-level model
module tb_tank_ctrl_gen;

    localparam int NK = 6;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic            frame_clk = 1'b0;
    logic [8*NK-1:0] keycodes = '0;
    logic [9:0]      DrawX = '0, DrawY = '0;
    logic            is_tank, fire_req, fire_ack, cooldown_busy;
    logic [9:0]      tank_X, tank_Y, shot_X, shot_Y;
    logic [2:0]      tank_dir, shot_dir;
    logic            is_tank2, fire_req2, busy2;
    logic [9:0]      tank_X2, tank_Y2, shot_X2, shot_Y2;
    logic [2:0]      tank_dir2, shot_dir2;
    logic [4:0]      ack_sr = '0;
    logic            ack_en = 1'b0;

    int checks = 0, failures = 0;

    tank_ctrl_gen dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycodes(keycodes),
        .DrawX(DrawX), .DrawY(DrawY), .is_tank(is_tank), .tank_X(tank_X), .tank_Y(tank_Y),
        .tank_dir(tank_dir), .fire_req(fire_req), .fire_ack(fire_ack), .shot_X(shot_X),
        .shot_Y(shot_Y), .shot_dir(shot_dir), .cooldown_busy(cooldown_busy)
    );

    tank_ctrl_gen #(.X_START(2), .STEP(4)) dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycodes(keycodes),
        .DrawX(DrawX), .DrawY(DrawY), .is_tank(is_tank2), .tank_X(tank_X2), .tank_Y(tank_Y2),
        .tank_dir(tank_dir2), .fire_req(fire_req2), .fire_ack(1'b0), .shot_X(shot_X2),
        .shot_Y(shot_Y2), .shot_dir(shot_dir2), .cooldown_busy(busy2)
    );

    always #10 Clk = ~Clk;

    // Bullet engine stand-in: acknowledges five cycles after it sees a request, when enabled.
    always @(posedge Clk) ack_sr <= {ack_sr[3:0], fire_req & ack_en};
    assign fire_ack = ack_sr[4];

    typedef struct { int x, y, d, x2, y2, d2, req; } exp_t;
    typedef struct { int f, x, y, d; } shot_t;

    exp_t  exp_q[$];
    shot_t shot_q[$];

    int mx, my, mdir, mx2, my2, mdir2, m_pending, m_cool, frame_num;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit held(input logic [8*NK-1:0] k, input logic [7:0] code);
        for (int i = 0; i < NK; i++) if (k[8*i +: 8] == code) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_move(input logic [8*NK-1:0] k, input int step,
                              inout int x, inout int y, inout int d);
        if (held(k, 8'h52)) begin
            d = 1; y = y - step; if (y < 0) y = 0;
        end else if (held(k, 8'h51)) begin
            d = 4; y = y + step; if (y > 480 - 32) y = 480 - 32;
        end else if (held(k, 8'h50)) begin
            d = 3; x = x - step; if (x < 0) x = 0;
        end else if (held(k, 8'h4F)) begin
            d = 2; x = x + step; if (x > 640 - 32) x = 640 - 32;
        end
    endtask

    task automatic model_reset();
        mx = 140; my = 240; mdir = 1;
        mx2 = 2; my2 = 240; mdir2 = 1;
        m_pending = 0; m_cool = 0;
    endtask

    task automatic frame(input logic [8*NK-1:0] k, input bit aen);
        int px, py, dx, dy;
        shot_t s;
        exp_t e;
        px = mx; py = my;
        model_move(k, 1, mx, my, mdir);
        model_move(k, 4, mx2, my2, mdir2);
        if (m_pending != 0) begin
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (held(k, 8'h58)) begin
            s.f = frame_num; s.d = mdir;
            case (mdir)
                1: begin s.x = px + 16; s.y = py;      end
                4: begin s.x = px + 16; s.y = py + 31; end
                3: begin s.x = px;      s.y = py + 16; end
                default: begin s.x = px + 31; s.y = py + 16; end
            endcase
            shot_q.push_back(s);
            m_pending = 1;
        end
        e.x = mx; e.y = my; e.d = mdir; e.x2 = mx2; e.y2 = my2; e.d2 = mdir2; e.req = m_pending;
        exp_q.push_back(e);
        if (m_pending != 0 && aen) begin
            m_pending = 0;
            m_cool = 15;
        end
        frame_num++;
        dx = mx + $urandom_range(0, 38) - 3;
        dy = my + $urandom_range(0, 38) - 3;
        if (dx < 0) dx = 0;
        if (dy < 0) dy = 0;
        #1;
        keycodes = k; ack_en = aen;
        DrawX = 10'(dx); DrawY = 10'(dy);
        frame_clk = 1'b1;
        repeat (8) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (12) @(posedge Clk);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("rst_fire_req", fire_req, 0);
        check("rst_busy", cooldown_busy, 0);
        check("rst_tank_X", tank_X, 140);
        check("rst_tank_Y", tank_Y, 240);
        check("rst_tank_dir", tank_dir, 1);
        check("rst_shot_X", shot_X, 0);
        repeat (6) @(posedge Clk);
        @(negedge Clk) Reset_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [8*NK-1:0] rand_keys();
        logic [8*NK-1:0] k;
        for (int i = 0; i < NK; i++) begin
            case ($urandom_range(0, 9))
                4: k[8*i +: 8] = 8'h52;
                5: k[8*i +: 8] = 8'h51;
                6: k[8*i +: 8] = 8'h50;
                7: k[8*i +: 8] = 8'h4F;
                8: k[8*i +: 8] = 8'h58;
                9: k[8*i +: 8] = 8'($urandom);
                default: k[8*i +: 8] = 8'h00;
            endcase
        end
        return k;
    endfunction

    // Monitor: compares the cycle after each frame tick, and every cycle a request is up.
    int    tick_cnt = 0;
    bit    tick_seen = 0, prev_req = 0;
    shot_t held_shot;
    always @(negedge Clk) begin
        exp_t e;
        int   it;
        if (!Reset_n) begin
            tick_seen = 0;
            prev_req  = 0;
        end else begin
            if (tick_seen) begin
                if (exp_q.size() == 0) check("exp_queue_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("tank_X", tank_X, e.x);
                    check("tank_Y", tank_Y, e.y);
                    check("tank_dir", tank_dir, e.d);
                    check("fire_req", fire_req, e.req);
                    check("step4_tank_X", tank_X2, e.x2);
                    check("step4_tank_Y", tank_Y2, e.y2);
                    check("step4_tank_dir", tank_dir2, e.d2);
                    it = (int'(DrawX) >= e.x && int'(DrawX) < e.x + 32 &&
                          int'(DrawY) >= e.y && int'(DrawY) < e.y + 32) ? 1 : 0;
                    check("is_tank", is_tank, it);
                end
            end
            tick_seen = dut.frame_tick;
            if (dut.frame_tick) tick_cnt++;
            if (fire_req && !prev_req) begin
                if (shot_q.size() == 0) check("unexpected_fire_req", 1, 0);
                else begin
                    held_shot = shot_q.pop_front();
                    check("shot_frame", tick_cnt - 1, held_shot.f);
                    check("shot_X", shot_X, held_shot.x);
                    check("shot_Y", shot_Y, held_shot.y);
                    check("shot_dir", shot_dir, held_shot.d);
                end
            end else if (fire_req && prev_req) begin
                check("shot_X_hold", shot_X, held_shot.x);
                check("shot_Y_hold", shot_Y, held_shot.y);
                check("shot_dir_hold", shot_dir, held_shot.d);
            end
            prev_req = fire_req;
        end
    end

    initial begin
        logic [8*NK-1:0] k;
        frame_num = 0;
        model_reset();
        do_reset();

        repeat (4) frame('0, 1'b1);

        k = '0; k[8*3 +: 8] = 8'h4F;
        repeat (10) frame(k, 1'b1);
        check("right10_tank_X", tank_X, 150);
        k = '0; k[7:0] = 8'h52; k[15:8] = 8'h50;
        repeat (10) frame(k, 1'b1);

        k = '0; k[8*5 +: 8] = 8'h50;
        repeat (155) frame(k, 1'b1);
        check("left_clamp_step4", tank_X2, 0);
        k = '0; k[8*1 +: 8] = 8'h51;
        repeat (230) frame(k, 1'b1);
        check("down_clamp", tank_Y, 448);

        do_reset();
        k = '0; k[8*2 +: 8] = 8'h58;
        repeat (40) frame(k, 1'b1);

        k[8*4 +: 8] = 8'h4F;
        repeat (100) frame(k, 1'b0);

        repeat (300) frame(rand_keys(), ($urandom_range(0, 3) != 0));

        do_reset();
        k = '0; k[8*0 +: 8] = 8'h58;
        frame(k, 1'b0);
        check("pre_rst_req", fire_req, 1);
        do_reset();
        frame(k, 1'b1);
        frame('0, 1'b1);
        check("pre_rst_cool_busy", cooldown_busy, 1);
        check("pre_rst_cool_req", fire_req, 0);
        do_reset();

        repeat (5) @(posedge Clk);
        check("exp_queue_drained", exp_q.size(), 0);
        check("shot_queue_drained", shot_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
